// File: rtl/bus_master.sv
// bus_master: turns a multiply request into operand-load, compute and wait bus cycles to a slave.
// Optional WAIT-state abort is built when BUS_MASTER_TIMEOUT_EN is defined.
module bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic        bus_valid,
  output logic        bus_start,
  output logic [31:0] bus_address,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_result,
  output logic [15:0] txn_count
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [15:0] txn_count_q, txn_count_d;

`ifdef BUS_MASTER_TIMEOUT_EN
  logic        resp_error_q, resp_error_d;
  logic [15:0] tmo_q, tmo_d;
  logic        tmo_hit;

  assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      resp_data_q  <= '0;
      txn_count_q  <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
      resp_error_q <= 1'b0;
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      resp_data_q  <= resp_data_d;
      txn_count_q  <= txn_count_d;
`ifdef BUS_MASTER_TIMEOUT_EN
      resp_error_q <= resp_error_d;
      tmo_q        <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    resp_data_d  = resp_data_q;
    txn_count_d  = txn_count_q;
`ifdef BUS_MASTER_TIMEOUT_EN
    resp_error_d = resp_error_q;
    tmo_d        = '0;
`endif
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    bus_valid    = 1'b0;
    bus_start    = 1'b0;
    bus_address  = '0;
    bus_wdata    = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        bus_valid   = 1'b1;
        bus_address = 32'd1;
        bus_wdata   = a_q;
        state_d     = LOAD_B;
      end
      LOAD_B: begin
        bus_valid   = 1'b1;
        bus_address = 32'd2;
        bus_wdata   = b_q;
        state_d     = START;
      end
      START: begin
        bus_valid = 1'b1;
        bus_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        bus_valid = 1'b1;
        bus_start = 1'b1;
        if (bus_ready) begin
          resp_data_d  = bus_result;
          txn_count_d  = txn_count_q + 16'd1;
`ifdef BUS_MASTER_TIMEOUT_EN
          resp_error_d = 1'b0;
`endif
          state_d      = RESP;
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        // tmo_q counts completed idle WAIT cycles; it falls back to zero outside WAIT
        else if (tmo_hit) begin
          resp_data_d  = '0;
          resp_error_d = 1'b1;
          txn_count_d  = txn_count_q + 16'd1;
          state_d      = RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_data = resp_data_q;
  assign txn_count = txn_count_q;
`ifdef BUS_MASTER_TIMEOUT_EN
  assign resp_error = resp_error_q;
`else
  assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master: stimulus queues hand-computed responses, a monitor checks them.
module tb_bus_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        bus_valid;
  logic        bus_start;
  logic [31:0] bus_address;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_result = '0;
  logic [15:0] txn_count;

  always #5 clk = ~clk;

  bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .bus_valid(bus_valid), .bus_start(bus_start), .bus_address(bus_address),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_result(bus_result),
    .txn_count(txn_count)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        err;
    logic [15:0] cnt;
    int unsigned lat;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned slv_delay = 0;
  logic        slv_stray = 1'b0;
  logic        done = 1'b0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Slave model: captures operand writes, answers slv_delay cycles into WAIT.
  initial begin : slave
    logic [31:0] sa;
    logic [31:0] sb;
    int unsigned scnt;
    sa = '0; sb = '0; scnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        scnt = 0; bus_ready = 1'b0; bus_result = '0;
      end else begin
        if (bus_valid && bus_address == 32'd1) sa = bus_wdata;
        if (bus_valid && bus_address == 32'd2) sb = bus_wdata;
        if (bus_valid && bus_start) scnt++;
        else scnt = 0;
        if (bus_valid && bus_start && scnt >= 2 + slv_delay) begin
          bus_ready  = 1'b1;
          bus_result = sa * sb;
        end else begin
          bus_ready  = slv_stray && !bus_start;
          bus_result = slv_stray ? 32'hDEAD_BEEF : 32'h0;
        end
      end
    end
  end

  initial begin : monitor
    int unsigned cyc;
    bit          inflight;
    logic [31:0] last_data;
    logic        last_err;
    exp_t        e;
    logic [66:0] bus_now;
    logic [66:0] bexp;
    cyc = 0; inflight = 0; last_data = '0; last_err = 1'b0;
    forever begin
      @(negedge clk or posedge reset or posedge done);
      bus_now = {bus_valid, bus_start, bus_address, bus_wdata, req_ready};
      if (done) begin
        chk("queue_drained", exp_q.size(), 0);
        chk("end_idle", {inflight, req_ready}, 2'b01);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end else if (reset) begin
        #1;
        if (inflight) void'(exp_q.pop_front());
        inflight = 0; last_data = '0; last_err = 1'b0;
        chk("reset_outputs",
            {bus_valid, bus_start, bus_address, bus_wdata, resp_valid, resp_data,
             resp_error, txn_count, req_ready}, 128'd1);
      end else begin
        if (inflight) begin
          cyc++;
          if (exp_q.size() == 0) begin
            chk("have_expected", 0, 1);
            inflight = 0;
          end else begin
            e = exp_q[0];
            if (resp_valid) begin
              chk("resp_bus", bus_now, 67'd0);
              chk("resp_data", resp_data, e.data);
              chk("resp_error", resp_error, e.err);
              chk("txn_count", txn_count, e.cnt);
              chk("latency", cyc, e.lat);
              last_data = e.data; last_err = e.err;
              void'(exp_q.pop_front());
              inflight = 0;
            end else begin
              case (cyc)
                1:       bexp = {1'b1, 1'b0, 32'd1, e.a, 1'b0};
                2:       bexp = {1'b1, 1'b0, 32'd2, e.b, 1'b0};
                default: bexp = {1'b1, 1'b1, 32'd0, 32'd0, 1'b0};
              endcase
              chk("bus_phase", bus_now, bexp);
              chk("resp_hold", {resp_data, resp_error}, {last_data, last_err});
              if (cyc > e.lat + 4) begin
                chk("resp_in_time", cyc, e.lat);
                void'(exp_q.pop_front());
                inflight = 0;
              end
            end
          end
        end else begin
          chk("idle", {bus_now, resp_valid, resp_data, resp_error},
              {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, last_data, last_err});
        end
        if (req_valid && req_ready) begin
          inflight = 1;
          cyc = 0;
        end
      end
    end
  end

  task automatic wait_ready();
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!req_ready) begin
      n++;
      if (n > 100) begin
        $display("FAIL wait_ready: req_ready=0 after 100 cycles, expected 1");
        $fatal(1);
      end
      @(negedge clk);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                      input logic er, input int unsigned lat);
    exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back('{a: a, b: b, data: d, err: er, cnt: exp_cnt, lat: lat});
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                     input int unsigned delay, input logic stray, input logic er,
                     input int unsigned lat);
    wait_ready();
    @(posedge clk); #1;
    slv_delay = delay;
    slv_stray = stray;
    push(a, b, d, er, lat);
    req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom;
  endtask

  initial begin : stimulus
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    run(32'd6, 32'd7, 32'd42, 0, 1'b0, 1'b0, 5);
    run(32'h0001_0000, 32'h0001_0000, 32'h0, 0, 1'b1, 1'b0, 5);
    run(32'd9, 32'd11, 32'd99, 3, 1'b0, 1'b0, 8);
`ifdef BUS_MASTER_TIMEOUT_EN
    run(32'd5, 32'd5, 32'd0, 1000, 1'b0, 1'b1, 20);
    run(32'd2, 32'd3, 32'd6, 0, 1'b0, 1'b0, 5);
`endif

    // Abort in LOAD_B; the monitor discards the in-flight expectation on reset.
    wait_ready();
    @(posedge clk); #1;
    slv_delay = 0; slv_stray = 1'b0;
    push(32'd100, 32'd200, 32'd20000, 1'b0, 5);
    req_a = 32'd100; req_b = 32'd200; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !(bus_valid && bus_address == 32'd2); i++) @(negedge clk);
    #2 reset = 1'b1;
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    run(32'd3, 32'd5, 32'd15, 0, 1'b0, 1'b0, 5);

    // Preload the counter just below wrap, then hold req_valid across two transactions.
    wait_ready();
    @(posedge clk); #1;
    force dut.txn_count_q = 16'hFFFE;
    #1 release dut.txn_count_q;
    exp_cnt = 16'hFFFE;
    slv_delay = 0;
    push(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 5);
    push(32'h8000_0000, 32'd3, 32'h8000_0000, 1'b0, 5);
    req_a = 32'hFFFF_FFFF; req_b = 32'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_a = 32'h8000_0000; req_b = 32'd3;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;

    wait_ready();
    repeat (3) @(negedge clk);
    #2 done = 1'b1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not complete by %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
